// File: rtl/mem_ctrl_pkg.sv
// Shared constants and op helpers for the memory controller.
package mem_ctrl_pkg;

    localparam int unsigned XLEN           = 32;
    localparam int unsigned ROB_SIZE_WIDTH = 4;
    localparam int unsigned INST_OP_WIDTH  = 6;

    localparam logic [XLEN-1:0] IO_BASE = 32'h0003_0000;

    localparam logic [INST_OP_WIDTH-1:0] LB  = 6'd10;
    localparam logic [INST_OP_WIDTH-1:0] LH  = 6'd11;
    localparam logic [INST_OP_WIDTH-1:0] LW  = 6'd12;
    localparam logic [INST_OP_WIDTH-1:0] LBU = 6'd13;
    localparam logic [INST_OP_WIDTH-1:0] LHU = 6'd14;
    localparam logic [INST_OP_WIDTH-1:0] SB  = 6'd15;
    localparam logic [INST_OP_WIDTH-1:0] SH  = 6'd16;
    localparam logic [INST_OP_WIDTH-1:0] SW  = 6'd17;

    // Access size in bytes for a load/store op; anything unknown is a word.
    function automatic logic [2:0] op_bytes(input logic [INST_OP_WIDTH-1:0] op);
        logic [2:0] n;
        n = 3'd4;
        if (op == LB || op == LBU || op == SB) n = 3'd1;
        if (op == LH || op == LHU || op == SH) n = 3'd2;
        return n;
    endfunction

endpackage

// File: rtl/mem_load_extend.sv
// Sign/zero extension of the assembled little-endian load bytes.
module mem_load_extend
    import mem_ctrl_pkg::*;
(
    input  logic [INST_OP_WIDTH-1:0] op,
    input  logic [XLEN-1:0]          raw,
    output logic [XLEN-1:0]          result
);

    // Pick the extension from the load op; only the low bytes are meaningful.
    always_comb begin
        result = raw;
        case (op)
            LB:      result = {{(XLEN-8){raw[7]}}, raw[7:0]};
            LH:      result = {{(XLEN-16){raw[15]}}, raw[15:0]};
            LBU:     result = {{(XLEN-8){1'b0}}, raw[7:0]};
            LHU:     result = {{(XLEN-16){1'b0}}, raw[15:0]};
            default: result = raw;
        endcase
    end

endmodule

// File: rtl/mem_ctrl.sv
// Byte-wide RAM/IO port owner: arbitrates store > load > fetch and sequences beats.
module mem_ctrl
    import mem_ctrl_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      rdy,
    input  logic                      flush,
    input  logic                      io_buffer_full,
    input  logic [7:0]                mem_din,
    output logic [7:0]                mem_dout,
    output logic [XLEN-1:0]           mem_a,
    output logic                      mem_wr,
    input  logic                      if_req,
    input  logic [XLEN-1:0]           if_addr,
    output logic                      if_data_ready,
    output logic [XLEN-1:0]           if_inst,
    input  logic                      lsb_mem_enable,
    input  logic [INST_OP_WIDTH-1:0]  lsb_mem_op,
    input  logic [XLEN-1:0]           lsb_mem_addr,
    input  logic [ROB_SIZE_WIDTH-1:0] lsb_mem_id,
    input  logic                      rob_mem_enable,
    input  logic [INST_OP_WIDTH-1:0]  rob_mem_op,
    input  logic [XLEN-1:0]           rob_mem_addr,
    input  logic [XLEN-1:0]           rob_mem_data,
    output logic                      mem_busy,
    output logic                      mem_data_ready,
    output logic [XLEN-1:0]           mem_data,
    output logic [ROB_SIZE_WIDTH-1:0] mem_id,
    output logic                      mem_store_done
);

    typedef enum logic [1:0] {S_IDLE, S_WAIT_IO, S_READ, S_WRITE} state_e;

    state_e                    state_q, state_d;
    logic [2:0]                cnt_q, cnt_d;
    logic [INST_OP_WIDTH-1:0]  op_q, op_d;
    logic [XLEN-1:0]           addr_q, addr_d;
    logic [XLEN-1:0]           wdata_q, wdata_d;
    logic [ROB_SIZE_WIDTH-1:0] id_q, id_d;
    logic                      fetch_q, fetch_d;
    logic [2:0]                nbytes_q, nbytes_d;
    logic [XLEN-1:0]           raw_q, raw_d;
    logic [7:0]                mem_dout_q, mem_dout_d;
    logic [XLEN-1:0]           mem_a_q, mem_a_d;
    logic                      mem_wr_q, mem_wr_d;
    logic                      mem_busy_q, mem_busy_d;
    logic                      mem_data_ready_q, mem_data_ready_d;
    logic [XLEN-1:0]           mem_data_q, mem_data_d;
    logic [ROB_SIZE_WIDTH-1:0] mem_id_q, mem_id_d;
    logic                      mem_store_done_q, mem_store_done_d;
    logic                      if_data_ready_q, if_data_ready_d;
    logic [XLEN-1:0]           if_inst_q, if_inst_d;

    logic                      idle_c, acc_store_c, acc_load_c, acc_fetch_c, store_wait_c;
    logic                      rd_last_c, wr_last_c;
    logic [2:0]                cnt_next_c;
    logic [1:0]                cap_idx_c;
    logic [XLEN-1:0]           raw_cap_c, ext_c;

    assign idle_c       = (state_q == S_IDLE);
    assign acc_store_c  = idle_c && rob_mem_enable;
    assign acc_load_c   = idle_c && lsb_mem_enable && !rob_mem_enable && !flush;
    assign acc_fetch_c  = idle_c && if_req && !rob_mem_enable && !lsb_mem_enable && !flush;
    assign store_wait_c = io_buffer_full &&
                          (rob_mem_addr == IO_BASE || rob_mem_addr == IO_BASE + XLEN'(4));
    assign cnt_next_c   = 3'(cnt_q + 3'd1);
    assign rd_last_c    = (state_q == S_READ) && (cnt_q == nbytes_q);
    assign wr_last_c    = (state_q == S_WRITE) && (cnt_next_c == nbytes_q);
    assign cap_idx_c    = 2'(cnt_q - 3'd1);

    // Merge the byte returning this cycle into the assembly buffer.
    always_comb begin
        raw_cap_c = raw_q;
        raw_cap_c[{cap_idx_c, 3'b000} +: 8] = mem_din;
    end

    mem_load_extend u_load_extend (
        .op     (op_q),
        .raw    (raw_cap_c),
        .result (ext_c)
    );

    // State and datapath registers; everything freezes while rdy is low.
    always_ff @(posedge clk) begin
        if (rdy) begin
            if (rst) begin
                state_q          <= S_IDLE;
                cnt_q            <= '0;
                op_q             <= '0;
                addr_q           <= '0;
                wdata_q          <= '0;
                id_q             <= '0;
                fetch_q          <= 1'b0;
                nbytes_q         <= '0;
                raw_q            <= '0;
                mem_dout_q       <= '0;
                mem_a_q          <= '0;
                mem_wr_q         <= 1'b0;
                mem_busy_q       <= 1'b0;
                mem_data_ready_q <= 1'b0;
                mem_data_q       <= '0;
                mem_id_q         <= '0;
                mem_store_done_q <= 1'b0;
                if_data_ready_q  <= 1'b0;
                if_inst_q        <= '0;
            end else begin
                state_q          <= state_d;
                cnt_q            <= cnt_d;
                op_q             <= op_d;
                addr_q           <= addr_d;
                wdata_q          <= wdata_d;
                id_q             <= id_d;
                fetch_q          <= fetch_d;
                nbytes_q         <= nbytes_d;
                raw_q            <= raw_d;
                mem_dout_q       <= mem_dout_d;
                mem_a_q          <= mem_a_d;
                mem_wr_q         <= mem_wr_d;
                mem_busy_q       <= mem_busy_d;
                mem_data_ready_q <= mem_data_ready_d;
                mem_data_q       <= mem_data_d;
                mem_id_q         <= mem_id_d;
                mem_store_done_q <= mem_store_done_d;
                if_data_ready_q  <= if_data_ready_d;
                if_inst_q        <= if_inst_d;
            end
        end
    end

    // Next state and beat counter.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (acc_store_c) begin
                    state_d = store_wait_c ? S_WAIT_IO : S_WRITE;
                    cnt_d   = '0;
                end else if (acc_load_c || acc_fetch_c) begin
                    state_d = S_READ;
                    cnt_d   = '0;
                end
            end
            S_WAIT_IO: begin
                if (!io_buffer_full) begin
                    state_d = S_WRITE;
                    cnt_d   = '0;
                end
            end
            S_READ: begin
                if (flush || rd_last_c) state_d = S_IDLE;
                else                    cnt_d   = cnt_next_c;
            end
            S_WRITE: begin
                if (wr_last_c) state_d = S_IDLE;
                else           cnt_d   = cnt_next_c;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Bus drive, request latching, byte capture and completion pulses.
    always_comb begin
        mem_a_d          = mem_a_q;
        mem_dout_d       = mem_dout_q;
        mem_wr_d         = 1'b0;
        mem_busy_d       = (state_d != S_IDLE);
        mem_data_ready_d = 1'b0;
        mem_store_done_d = 1'b0;
        if_data_ready_d  = 1'b0;
        mem_data_d       = mem_data_q;
        mem_id_d         = mem_id_q;
        if_inst_d        = if_inst_q;
        op_d             = op_q;
        addr_d           = addr_q;
        wdata_d          = wdata_q;
        id_d             = id_q;
        fetch_d          = fetch_q;
        nbytes_d         = nbytes_q;
        raw_d            = raw_q;
        case (state_q)
            S_IDLE: begin
                if (acc_store_c) begin
                    op_d     = rob_mem_op;
                    addr_d   = rob_mem_addr;
                    wdata_d  = rob_mem_data;
                    nbytes_d = op_bytes(rob_mem_op);
                    if (!store_wait_c) begin
                        mem_wr_d   = 1'b1;
                        mem_a_d    = rob_mem_addr;
                        mem_dout_d = rob_mem_data[7:0];
                    end
                end else if (acc_load_c) begin
                    op_d     = lsb_mem_op;
                    addr_d   = lsb_mem_addr;
                    id_d     = lsb_mem_id;
                    fetch_d  = 1'b0;
                    nbytes_d = op_bytes(lsb_mem_op);
                    mem_a_d  = lsb_mem_addr;
                end else if (acc_fetch_c) begin
                    op_d     = LW;
                    addr_d   = if_addr;
                    fetch_d  = 1'b1;
                    nbytes_d = 3'd4;
                    mem_a_d  = if_addr;
                end
            end
            S_WAIT_IO: begin
                if (!io_buffer_full) begin
                    mem_wr_d   = 1'b1;
                    mem_a_d    = addr_q;
                    mem_dout_d = wdata_q[7:0];
                end
            end
            S_READ: begin
                if (!flush) begin
                    if (cnt_q != 3'd0) raw_d = raw_cap_c;
                    if (rd_last_c) begin
                        if (fetch_q) begin
                            if_data_ready_d = 1'b1;
                            if_inst_d       = raw_cap_c;
                        end else begin
                            mem_data_ready_d = 1'b1;
                            mem_data_d       = ext_c;
                            mem_id_d         = id_q;
                        end
                    end else if (cnt_next_c < nbytes_q) begin
                        mem_a_d = addr_q + XLEN'(cnt_next_c);
                    end
                end
            end
            S_WRITE: begin
                if (wr_last_c) begin
                    mem_store_done_d = 1'b1;
                end else begin
                    mem_wr_d   = 1'b1;
                    mem_a_d    = addr_q + XLEN'(cnt_next_c);
                    mem_dout_d = wdata_q[{cnt_next_c[1:0], 3'b000} +: 8];
                end
            end
            default: ;
        endcase
    end

    assign mem_dout       = mem_dout_q;
    assign mem_a          = mem_a_q;
    assign mem_wr         = mem_wr_q;
    assign mem_busy       = mem_busy_q;
    assign mem_data_ready = mem_data_ready_q;
    assign mem_data       = mem_data_q;
    assign mem_id         = mem_id_q;
    assign mem_store_done = mem_store_done_q;
    assign if_data_ready  = if_data_ready_q;
    assign if_inst        = if_inst_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// Randomized bench for mem_ctrl against a transaction-level memory model.
module tb_mem_ctrl;
    import mem_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        rst, rdy, flush, io_buffer_full;
    logic [7:0]  mem_din, mem_dout;
    logic [31:0] mem_a;
    logic        mem_wr;
    logic        if_req, if_data_ready;
    logic [31:0] if_addr, if_inst;
    logic        lsb_mem_enable;
    logic [5:0]  lsb_mem_op;
    logic [31:0] lsb_mem_addr;
    logic [3:0]  lsb_mem_id;
    logic        rob_mem_enable;
    logic [5:0]  rob_mem_op;
    logic [31:0] rob_mem_addr, rob_mem_data;
    logic        mem_busy, mem_data_ready, mem_store_done;
    logic [31:0] mem_data;
    logic [3:0]  mem_id;

    int checks = 0;
    int failures = 0;

    logic [7:0] ram     [logic [31:0]];
    logic [7:0] ref_mem [logic [31:0]];

    always #5 clk = ~clk;

    mem_ctrl u_dut (
        .clk(clk), .rst(rst), .rdy(rdy), .flush(flush), .io_buffer_full(io_buffer_full),
        .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
        .if_req(if_req), .if_addr(if_addr), .if_data_ready(if_data_ready), .if_inst(if_inst),
        .lsb_mem_enable(lsb_mem_enable), .lsb_mem_op(lsb_mem_op), .lsb_mem_addr(lsb_mem_addr),
        .lsb_mem_id(lsb_mem_id), .rob_mem_enable(rob_mem_enable), .rob_mem_op(rob_mem_op),
        .rob_mem_addr(rob_mem_addr), .rob_mem_data(rob_mem_data), .mem_busy(mem_busy),
        .mem_data_ready(mem_data_ready), .mem_data(mem_data), .mem_id(mem_id),
        .mem_store_done(mem_store_done)
    );

    // RAM device: one-cycle read latency, write on the edge.
    always @(posedge clk) begin
        mem_din <= ram.exists(mem_a) ? ram[mem_a] : 8'h00;
        if (mem_wr) ram[mem_a] = mem_dout;
    end

    always @(posedge clk)
        assert (!(lsb_mem_enable && rob_mem_enable)) else $error("load and store pulse together");

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int nbytes_of(input logic [5:0] op);
        if (op == LB || op == LBU || op == SB) return 1;
        if (op == LH || op == LHU || op == SH) return 2;
        return 4;
    endfunction

    function automatic logic [7:0] ref_byte(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : 8'h00;
    endfunction

    // Value a load should return: little-endian sum of bytes, signed ops wrap negative.
    function automatic logic [31:0] ref_load(input logic [5:0] op, input logic [31:0] a);
        longint v, span;
        int     n;
        n = nbytes_of(op);
        v = 0;
        for (int i = 0; i < n; i++)
            v = v + longint'(ref_byte(a + 32'(i))) * (longint'(1) << (8 * i));
        span = longint'(1) << (8 * n);
        if ((op == LB || op == LH) && v >= span / 2) v = v - span;
        return 32'(v);
    endfunction

    task automatic put_byte(input logic [31:0] a, input logic [7:0] b);
        ram[a] = b;
        ref_mem[a] = b;
    endtask

    // Load or fetch; flush_k > 0 raises flush in cycle T+flush_k.
    task automatic do_read(input bit is_fetch, input logic [5:0] op, input logic [31:0] addr,
                           input logic [3:0] id, input int flush_k);
        int          n;
        logic [31:0] exp;
        bit          aborted;
        n = is_fetch ? 4 : nbytes_of(op);
        exp = ref_load(is_fetch ? LW : op, addr);
        aborted = 0;
        if (is_fetch) begin
            if_req = 1'b1; if_addr = addr;
        end else begin
            lsb_mem_enable = 1'b1; lsb_mem_op = op; lsb_mem_addr = addr; lsb_mem_id = id;
        end
        @(negedge clk);
        check_eq("rd_accept_busy", 32'(mem_busy), 32'd0);
        tick();
        if_req = 1'b0; if_addr = $urandom;
        lsb_mem_enable = 1'b0; lsb_mem_addr = $urandom; lsb_mem_id = 4'($urandom);
        for (int k = 1; k <= n + 1 && !aborted; k++) begin
            flush = (k == flush_k);
            @(negedge clk);
            check_eq("rd_busy", 32'(mem_busy), 32'd1);
            check_eq("rd_no_wr", 32'(mem_wr), 32'd0);
            check_eq("rd_early_ready", 32'(mem_data_ready | if_data_ready), 32'd0);
            if (k <= n) check_eq("rd_addr", mem_a, addr + 32'(k - 1));
            tick();
            if (flush) begin
                flush = 1'b0;
                aborted = 1;
            end
        end
        @(negedge clk);
        check_eq("rd_done_idle", 32'(mem_busy), 32'd0);
        if (aborted) begin
            check_eq("rd_flush_no_pulse", 32'(mem_data_ready | if_data_ready), 32'd0);
        end else if (is_fetch) begin
            check_eq("if_ready", 32'(if_data_ready), 32'd1);
            check_eq("if_inst", if_inst, exp);
            check_eq("if_no_ld_ready", 32'(mem_data_ready), 32'd0);
        end else begin
            check_eq("ld_ready", 32'(mem_data_ready), 32'd1);
            check_eq("ld_data", mem_data, exp);
            check_eq("ld_id", 32'(mem_id), 32'(id));
            check_eq("ld_no_if_ready", 32'(if_data_ready), 32'd0);
        end
        tick();
        @(negedge clk);
        check_eq("rd_pulse_once", 32'(mem_data_ready | if_data_ready), 32'd0);
        if (!aborted && !is_fetch) check_eq("ld_data_hold", mem_data, exp);
        tick();
    endtask

    // Store with optional IO stall (cycles io_buffer_full stays high) and flush cycle.
    task automatic do_store(input logic [5:0] op, input logic [31:0] addr, input logic [31:0] data,
                            input int stall, input int flush_k);
        int n, eff;
        bit io;
        n = nbytes_of(op);
        io = (addr == IO_BASE) || (addr == IO_BASE + 32'd4);
        eff = io ? stall : 0;
        rob_mem_enable = 1'b1; rob_mem_op = op; rob_mem_addr = addr; rob_mem_data = data;
        io_buffer_full = io ? (stall > 0) : 1'($urandom);
        for (int i = 0; i < n; i++) ref_mem[addr + 32'(i)] = data[8 * i +: 8];
        @(negedge clk);
        check_eq("st_accept_busy", 32'(mem_busy), 32'd0);
        tick();
        rob_mem_enable = 1'b0; rob_mem_op = 6'($urandom);
        rob_mem_addr = $urandom; rob_mem_data = $urandom;
        for (int s = 1; s <= eff; s++) begin
            io_buffer_full = (s < eff);
            @(negedge clk);
            check_eq("st_stall_no_wr", 32'(mem_wr), 32'd0);
            check_eq("st_stall_busy", 32'(mem_busy), 32'd1);
            tick();
        end
        for (int k = 1; k <= n; k++) begin
            io_buffer_full = 1'($urandom);
            flush = (k == flush_k);
            @(negedge clk);
            check_eq("st_wr", 32'(mem_wr), 32'd1);
            check_eq("st_addr", mem_a, addr + 32'(k - 1));
            check_eq("st_dout", 32'(mem_dout), 32'(data[8 * (k - 1) +: 8]));
            check_eq("st_busy", 32'(mem_busy), 32'd1);
            check_eq("st_early_done", 32'(mem_store_done), 32'd0);
            tick();
        end
        flush = 1'b0;
        @(negedge clk);
        check_eq("st_end_no_wr", 32'(mem_wr), 32'd0);
        check_eq("st_done", 32'(mem_store_done), 32'd1);
        check_eq("st_end_idle", 32'(mem_busy), 32'd0);
        tick();
        @(negedge clk);
        check_eq("st_done_once", 32'(mem_store_done), 32'd0);
        tick();
    endtask

    function automatic logic [31:0] pick_addr();
        case ($urandom_range(0, 3))
            0:       return 32'hFFFF_FFFC + 32'($urandom_range(0, 3));
            default: return 32'h0000_1000 + 32'($urandom_range(0, 255));
        endcase
    endfunction

    logic [5:0] ld_ops [5] = '{LB, LH, LW, LBU, LHU};
    logic [5:0] st_ops [3] = '{SB, SH, SW};

    initial begin
        logic [5:0]  op;
        logic [31:0] a;
        int          n;

        rst = 1'b1; rdy = 1'b1; flush = 1'b0; io_buffer_full = 1'b0;
        if_req = 1'b0; if_addr = '0;
        lsb_mem_enable = 1'b0; lsb_mem_op = '0; lsb_mem_addr = '0; lsb_mem_id = '0;
        rob_mem_enable = 1'b0; rob_mem_op = '0; rob_mem_addr = '0; rob_mem_data = '0;

        for (int i = 0; i < 256; i++) put_byte(32'h1000 + 32'(i), 8'($urandom));
        for (int i = 0; i < 4; i++) begin
            put_byte(32'hFFFF_FFFC + 32'(i), 8'($urandom));
            put_byte(32'(i), 8'($urandom));
        end
        put_byte(32'h100, 8'h11); put_byte(32'h101, 8'h22);
        put_byte(32'h102, 8'h33); put_byte(32'h103, 8'h44);
        put_byte(32'h200, 8'h80);
        put_byte(32'h210, 8'h01); put_byte(32'h211, 8'h80);

        tick(); tick();
        @(negedge clk);
        check_eq("rst_busy", 32'(mem_busy), 32'd0);
        check_eq("rst_wr", 32'(mem_wr), 32'd0);
        check_eq("rst_a", mem_a, 32'd0);
        check_eq("rst_pulses", 32'({mem_data_ready, if_data_ready, mem_store_done}), 32'd0);
        check_eq("rst_data", mem_data, 32'd0);
        tick();
        rst = 1'b0;
        tick();

        // Directed loads and stores.
        check_eq("lw_model", ref_load(LW, 32'h100), 32'h4433_2211);
        do_read(0, LW, 32'h100, 4'd5, 0);
        do_read(0, LB, 32'h200, 4'd6, 0);
        do_read(0, LBU, 32'h200, 4'd7, 0);
        do_read(0, LH, 32'h210, 4'd8, 0);
        do_store(SW, 32'h300, 32'hDEAD_BEEF, 0, 0);
        do_read(0, LW, 32'h300, 4'd1, 0);

        // Load and fetch requested together: load first, fetch accepted on the ready cycle.
        lsb_mem_enable = 1'b1; lsb_mem_op = LW; lsb_mem_addr = 32'h100; lsb_mem_id = 4'd9;
        if_req = 1'b1; if_addr = 32'h1040;
        tick();
        lsb_mem_enable = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            check_eq("prio_busy", 32'(mem_busy), 32'd1);
            if (k <= 4) check_eq("prio_ld_addr", mem_a, 32'h100 + 32'(k - 1));
            tick();
        end
        @(negedge clk);
        check_eq("prio_ld_ready", 32'(mem_data_ready), 32'd1);
        check_eq("prio_ld_data", mem_data, 32'h4433_2211);
        check_eq("prio_ld_id", 32'(mem_id), 32'd9);
        tick();
        if_req = 1'b0;
        @(negedge clk);
        check_eq("prio_if_busy", 32'(mem_busy), 32'd1);
        check_eq("prio_if_addr", mem_a, 32'h1040);
        for (int k = 8; k <= 11; k++) begin
            tick();
            @(negedge clk);
            check_eq("prio_if_early", 32'(if_data_ready), 32'd0);
        end
        tick();
        @(negedge clk);
        check_eq("prio_if_ready", 32'(if_data_ready), 32'd1);
        check_eq("prio_if_inst", if_inst, ref_load(LW, 32'h1040));
        tick();
        tick();

        // IO store held off by a full UART buffer, fetch flushed, store ignoring flush.
        do_store(SB, IO_BASE, 32'h0000_0041, 5, 0);
        do_read(1, LW, 32'h1000, 4'd0, 3);
        do_store(SW, 32'h1010, 32'hCAFE_F00D, 0, 2);

        // Load pulse with flush is dropped; pending fetch is also held off by flush.
        lsb_mem_enable = 1'b1; lsb_mem_op = LW; lsb_mem_addr = 32'h100; flush = 1'b1; if_req = 1'b1;
        tick();
        lsb_mem_enable = 1'b0; flush = 1'b0; if_req = 1'b0;
        @(negedge clk);
        check_eq("flush_drop_busy", 32'(mem_busy), 32'd0);
        tick();

        // Random traffic.
        for (int t = 0; t < 80; t++) begin
            a = pick_addr();
            case ($urandom_range(0, 2))
                0: begin
                    op = ld_ops[$urandom_range(0, 4)];
                    n = nbytes_of(op);
                    do_read(0, op, a, 4'($urandom),
                            ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, n + 1)) : 0);
                end
                1: begin
                    op = st_ops[$urandom_range(0, 2)];
                    if ($urandom_range(0, 3) == 0) a = IO_BASE + 32'(4 * $urandom_range(0, 1));
                    do_store(op, a, $urandom, int'($urandom_range(0, 4)), int'($urandom_range(0, 4)));
                end
                default: begin
                    do_read(1, LW, a, 4'd0, ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 5)) : 0);
                end
            endcase
            repeat ($urandom_range(0, 2)) begin
                @(negedge clk);
                check_eq("gap_idle", 32'(mem_busy), 32'd0);
                tick();
            end
        end

        // Reset in the middle of a load.
        lsb_mem_enable = 1'b1; lsb_mem_op = LW; lsb_mem_addr = 32'h100; lsb_mem_id = 4'd3;
        tick();
        lsb_mem_enable = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        check_eq("rrd_busy", 32'(mem_busy), 32'd0);
        check_eq("rrd_a", mem_a, 32'd0);
        check_eq("rrd_dout", 32'(mem_dout), 32'd0);
        check_eq("rrd_data", mem_data, 32'd0);
        check_eq("rrd_id", 32'(mem_id), 32'd0);
        check_eq("rrd_inst", if_inst, 32'd0);
        check_eq("rrd_pulses", 32'({mem_data_ready, if_data_ready, mem_store_done}), 32'd0);
        for (int k = 0; k < 6; k++) begin
            tick();
            @(negedge clk);
            check_eq("rrd_no_ready", 32'(mem_data_ready), 32'd0);
        end
        tick();

        // Reset in the middle of a store (scratch address never read back).
        rob_mem_enable = 1'b1; rob_mem_op = SW; rob_mem_addr = 32'h5000; rob_mem_data = 32'h1234_5678;
        io_buffer_full = 1'b0;
        tick();
        rob_mem_enable = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        check_eq("rwr_no_wr", 32'(mem_wr), 32'd0);
        check_eq("rwr_busy", 32'(mem_busy), 32'd0);
        tick();
        @(negedge clk);
        check_eq("rwr_no_done", 32'(mem_store_done), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
